pixel_integrator: RTL and testbench

PIXEL_INTEGRATOR -- requirements
Module: pixel_integrator

---
 rtl/pixel_integrator.sv | 176 +++++++++++++++++
 tb/tb_pixel_integrator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_integrator.sv
// Pixel integrator: per-pixel, per-channel saturating counters held in an
// external frame-buffer RAM. Each visible pixel reads its word, steps every
// channel up or down according to the comparator bit, and writes it back two
// cycles later. Hazard forwarding covers writes that the RAM has not absorbed
// yet. A clear request sweeps zeros through the whole buffer.
module pixel_integrator #(
    parameter int CHANNELS = 3,
    parameter int CW       = 5,
    parameter int ADDR_W   = 16,
    parameter int STEP     = 1,
    parameter int OUT_W    = 8
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      visible,
    input  logic [ADDR_W-1:0]         address,
    input  logic [CHANNELS-1:0]       comp,
    input  logic                      enable,
    input  logic                      freeze,
    input  logic [CHANNELS-1:0]       mask,
    input  logic                      clear,
    output logic [ADDR_W-1:0]         ram_rdaddr,
    input  logic [CHANNELS*CW-1:0]    ram_q,
    output logic [ADDR_W-1:0]         ram_wraddr,
    output logic [CHANNELS*CW-1:0]    ram_wdata,
    output logic                      ram_wren,
    output logic [CHANNELS*OUT_W-1:0] color_out,
    output logic                      busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [CW-1:0] MAX_VAL  = '1;
    localparam logic [CW:0]   STEP_EXT = (CW+1)'(STEP);

    state_t                   state;
    state_t                   state_next;
    logic [ADDR_W-1:0]        sweep_cnt;

    // Stage-1 copies of the pixel inputs, aligned with ram_q.
    logic                     s1_upd;
    logic                     s1_vis;
    logic [ADDR_W-1:0]        s1_addr;
    logic [CHANNELS-1:0]      s1_comp;
    logic [CHANNELS-1:0]      s1_mask;

    // Last write the RAM committed; its read port still returned old data.
    logic                     fw_valid;
    logic [ADDR_W-1:0]        fw_addr;
    logic [CHANNELS*CW-1:0]   fw_data;

    logic [CHANNELS*CW-1:0]   fwd_word;
    logic [CHANNELS*CW-1:0]   new_word;
    logic [CHANNELS*OUT_W-1:0] pix_word;

    logic                     start_clear;

    // Reads always follow the incoming pixel address.
    assign ram_rdaddr  = address;
    assign start_clear = (state == IDLE) && (state_next == CLEAR);

    // Next-state logic: a clear request starts a sweep, the last address ends it.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (clear) state_next = CLEAR;
            CLEAR:   if (sweep_cnt == '1) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register, sweep address counter and busy flag aligned with sweep writes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sweep_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state == CLEAR);
            if (state == CLEAR && sweep_cnt != '1) begin
                sweep_cnt <= sweep_cnt + 1'b1;
            end else begin
                sweep_cnt <= '0;
            end
        end
    end

    // Capture the pixel inputs; updates are only armed in IDLE with no clear pending.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_upd  <= 1'b0;
            s1_vis  <= 1'b0;
            s1_addr <= '0;
            s1_comp <= '0;
            s1_mask <= '0;
        end else begin
            s1_upd  <= visible && enable && !freeze && (state == IDLE) && !clear;
            s1_vis  <= visible && (state == IDLE) && !clear;
            s1_addr <= address;
            s1_comp <= comp;
            s1_mask <= mask;
        end
    end

    // Pick the freshest copy of the stage-1 word: pending write, then committed write, then RAM.
    always_comb begin
        fwd_word = ram_q;
        if (fw_valid && fw_addr == s1_addr) fwd_word = fw_data;
        if (ram_wren && ram_wraddr == s1_addr) fwd_word = ram_wdata;
    end

    // Per-channel saturating step and display value from the pre-update word.
    always_comb begin
        logic [CW-1:0]       v;
        logic [CW:0]         sum;
        logic [CW:0]         diff;
        logic [CW+OUT_W-1:0] wide;
        new_word = '0;
        pix_word = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            v    = fwd_word[k*CW +: CW];
            sum  = {1'b0, v} + STEP_EXT;
            diff = {1'b0, v} - STEP_EXT;
            wide = {v, {OUT_W{1'b0}}};
            if (s1_comp[k]) begin
                new_word[k*CW +: CW] = sum[CW] ? MAX_VAL : sum[CW-1:0];
            end else begin
                new_word[k*CW +: CW] = diff[CW] ? '0 : diff[CW-1:0];
            end
            if (s1_vis && !s1_mask[k]) begin
                pix_word[k*OUT_W +: OUT_W] = wide[CW+OUT_W-1 -: OUT_W];
            end
        end
    end

    // Write port and colour output; sweep writes override pixel updates, and
    // entering a clear drops whatever pixel write was about to be issued.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ram_wren   <= 1'b0;
            ram_wraddr <= '0;
            ram_wdata  <= '0;
            color_out  <= '0;
            fw_valid   <= 1'b0;
            fw_addr    <= '0;
            fw_data    <= '0;
        end else begin
            fw_valid <= ram_wren;
            fw_addr  <= ram_wraddr;
            fw_data  <= ram_wdata;
            if (state == CLEAR) begin
                ram_wren   <= 1'b1;
                ram_wraddr <= sweep_cnt;
                ram_wdata  <= '0;
            end else if (start_clear) begin
                ram_wren <= 1'b0;
            end else begin
                ram_wren <= s1_upd;
                if (s1_upd) begin
                    ram_wraddr <= s1_addr;
                    ram_wdata  <= new_word;
                end
            end
            if (state == CLEAR || start_clear) begin
                color_out <= '0;
            end else begin
                color_out <= pix_word;
            end
        end
    end

endmodule

// File: tb/tb_pixel_integrator.sv
// Directed bench for pixel_integrator: two instances (STEP=1 and STEP=4) on a
// 16-entry frame buffer, each backed by a registered-read RAM model.
module tb_pixel_integrator;

    localparam int CHANNELS = 3;
    localparam int CW       = 5;
    localparam int ADDR_W   = 4;
    localparam int OUT_W    = 8;
    localparam int DW       = CHANNELS*CW;

    logic                      clock;
    logic                      reset;
    logic                      visible;
    logic [ADDR_W-1:0]         address;
    logic [CHANNELS-1:0]       comp;
    logic                      enable;
    logic                      freeze;
    logic [CHANNELS-1:0]       mask;
    logic                      clear;

    logic [ADDR_W-1:0]         ram_rdaddr, ram_wraddr;
    logic [DW-1:0]             ram_q, ram_wdata;
    logic                      ram_wren, busy;
    logic [CHANNELS*OUT_W-1:0] color_out;

    logic [ADDR_W-1:0]         ram_rdaddr4, ram_wraddr4;
    logic [DW-1:0]             ram_q4, ram_wdata4;
    logic                      ram_wren4, busy4;
    logic [CHANNELS*OUT_W-1:0] color_out4;

    logic [DW-1:0] mem  [16];
    logic [DW-1:0] mem4 [16];

    int total;
    int bad;

    pixel_integrator #(.CHANNELS(CHANNELS), .CW(CW), .ADDR_W(ADDR_W), .STEP(1), .OUT_W(OUT_W)) dut (
        .clock(clock), .reset(reset), .visible(visible), .address(address), .comp(comp),
        .enable(enable), .freeze(freeze), .mask(mask), .clear(clear),
        .ram_rdaddr(ram_rdaddr), .ram_q(ram_q), .ram_wraddr(ram_wraddr), .ram_wdata(ram_wdata),
        .ram_wren(ram_wren), .color_out(color_out), .busy(busy)
    );

    pixel_integrator #(.CHANNELS(CHANNELS), .CW(CW), .ADDR_W(ADDR_W), .STEP(4), .OUT_W(OUT_W)) dut4 (
        .clock(clock), .reset(reset), .visible(visible), .address(address), .comp(comp),
        .enable(enable), .freeze(freeze), .mask(mask), .clear(clear),
        .ram_rdaddr(ram_rdaddr4), .ram_q(ram_q4), .ram_wraddr(ram_wraddr4), .ram_wdata(ram_wdata4),
        .ram_wren(ram_wren4), .color_out(color_out4), .busy(busy4)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // RAM models: registered read returning old data on a same-edge write.
    always @(posedge clock) begin
        ram_q  <= mem[ram_rdaddr];
        ram_q4 <= mem4[ram_rdaddr4];
        if (ram_wren)  mem[ram_wraddr]   <= ram_wdata;
        if (ram_wren4) mem4[ram_wraddr4] <= ram_wdata4;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic apply_stimulus(input logic vis, input logic [ADDR_W-1:0] addr,
                                  input logic [CHANNELS-1:0] cmp, input logic en,
                                  input logic frz, input logic [CHANNELS-1:0] msk,
                                  input logic clr);
        visible = vis;
        address = addr;
        comp    = cmp;
        enable  = en;
        freeze  = frz;
        mask    = msk;
        clear   = clr;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [DW-1:0] pack3(input int c2, input int c1, input int c0);
        logic [DW-1:0] w;
        w = {CW'(c2), CW'(c1), CW'(c0)};
        return w;
    endfunction

    // Directed sequence: reset, arithmetic, hazards, display, freeze, clear, abort.
    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            mem[i]  = '0;
            mem4[i] = '0;
        end
        mem[3]  = pack3(31, 31, 31);
        mem4[3] = pack3(0, 10, 29);
        mem[4]  = pack3(0, 0, 0);
        mem4[4] = pack3(2, 2, 2);
        mem[6]  = pack3(1, 20, 10);
        mem[2]  = pack3(5, 5, 5);
        mem[8]  = pack3(10, 10, 10);
        mem[9]  = pack3(0, 0, 0);
        mem[10] = pack3(22, 22, 22);

        repeat (2) tick();
        check_output("rst_wren",   32'(ram_wren),   32'd0);
        check_output("rst_busy",   32'(busy),       32'd0);
        check_output("rst_wraddr", 32'(ram_wraddr), 32'd0);
        check_output("rst_wdata",  32'(ram_wdata),  32'd0);
        check_output("rst_color",  32'(color_out),  32'd0);
        reset = 1'b0;
        tick();
        apply_stimulus(0, 5, 0, 0, 0, 0, 0);
        #1;
        check_output("rdaddr_idle", 32'(ram_rdaddr), 32'd5);
        tick();

        // Saturation up (STEP=1) and up with clipping on the STEP=4 instance.
        apply_stimulus(1, 3, 3'b111, 1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("sat_up_wren",   32'(ram_wren),   32'd1);
        check_output("sat_up_addr",   32'(ram_wraddr), 32'd3);
        check_output("sat_up_data",   32'(ram_wdata),  32'(pack3(31, 31, 31)));
        check_output("sat_up_color",  32'(color_out),  32'hF8F8F8);
        check_output("step4_up_data", 32'(ram_wdata4), 32'(pack3(4, 14, 31)));

        // Saturation down: 0 stays 0; 2 minus 4 clamps to 0.
        apply_stimulus(1, 4, 3'b000, 1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("sat_dn_wren",    32'(ram_wren),   32'd1);
        check_output("sat_dn_data",    32'(ram_wdata),  32'd0);
        check_output("step4_dn_data",  32'(ram_wdata4), 32'd0);

        // Mixed directions per channel.
        apply_stimulus(1, 6, 3'b010, 1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("mixed_data",  32'(ram_wdata), 32'(pack3(0, 21, 9)));
        check_output("mixed_color", 32'(color_out), 32'h08A050);

        // Same address three cycles in a row: 5 -> 6, 7, 8.
        apply_stimulus(1, 2, 3'b111, 1, 0, 0, 0);
        tick();
        tick();
        check_output("haz_w1", 32'(ram_wdata), 32'(pack3(6, 6, 6)));
        tick();
        check_output("haz_w2", 32'(ram_wdata), 32'(pack3(7, 7, 7)));
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("haz_w3",   32'(ram_wdata),  32'(pack3(8, 8, 8)));
        check_output("haz_addr", 32'(ram_wraddr), 32'd2);

        // A, B, A: the second A needs the already-committed write.
        apply_stimulus(1, 8, 3'b111, 1, 0, 0, 0);
        tick();
        apply_stimulus(1, 9, 3'b111, 1, 0, 0, 0);
        tick();
        apply_stimulus(1, 8, 3'b111, 1, 0, 0, 0);
        check_output("aba_w1", 32'(ram_wdata), 32'(pack3(11, 11, 11)));
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("aba_w2", 32'(ram_wdata), 32'(pack3(1, 1, 1)));
        tick();
        check_output("aba_w3",    32'(ram_wdata),  32'(pack3(12, 12, 12)));
        check_output("aba_addr3", 32'(ram_wraddr), 32'd8);

        // Display with channel 1 masked, then invisible pixel.
        apply_stimulus(1, 10, 3'b000, 0, 0, 3'b010, 0);
        tick();
        tick();
        check_output("mask_color", 32'(color_out), 32'hB000B0);
        check_output("mask_wren",  32'(ram_wren),  32'd0);
        apply_stimulus(0, 10, 3'b000, 0, 0, 3'b000, 0);
        tick();
        tick();
        check_output("invis_color", 32'(color_out), 32'd0);

        // Freeze: display continues, no writes.
        apply_stimulus(1, 10, 3'b111, 1, 1, 0, 0);
        tick();
        tick();
        check_output("frz_wren",  32'(ram_wren),  32'd0);
        check_output("frz_color", 32'(color_out), 32'hB0B0B0);
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Clear right behind a pixel update: the update is dropped.
        apply_stimulus(1, 11, 3'b111, 1, 0, 0, 0);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        check_output("clr_drop_wren", 32'(ram_wren), 32'd0);
        check_output("clr_pre_busy",  32'(busy),     32'd0);
        for (int i = 0; i < 16; i++) begin
            tick();
            check_output($sformatf("sweep_wren_%0d", i), 32'(ram_wren),   32'd1);
            check_output($sformatf("sweep_addr_%0d", i), 32'(ram_wraddr), 32'(i));
            check_output($sformatf("sweep_data_%0d", i), 32'(ram_wdata),  32'd0);
            check_output($sformatf("sweep_busy_%0d", i), 32'(busy),       32'd1);
            if (i == 3) apply_stimulus(1, 5, 3'b111, 1, 0, 0, 1);
            if (i == 4) apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        end
        tick();
        check_output("post_sweep_busy", 32'(busy),     32'd0);
        check_output("post_sweep_wren", 32'(ram_wren), 32'd0);
        tick();
        check_output("no_rewrap_wren", 32'(ram_wren), 32'd0);
        check_output("cleared_mem2",   32'(mem[2]),   32'd0);

        // Reset in the middle of a sweep aborts it immediately.
        apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        tick();
        apply_stimulus(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_output("abort_first_addr", 32'(ram_wraddr), 32'd0);
        repeat (7) tick();
        check_output("abort_at7_addr", 32'(ram_wraddr), 32'd7);
        check_output("abort_at7_busy", 32'(busy),       32'd1);
        reset = 1'b1;
        #1;
        check_output("abort_wren", 32'(ram_wren), 32'd0);
        check_output("abort_busy", 32'(busy),     32'd0);
        tick();
        reset = 1'b0;
        apply_stimulus(0, 9, 0, 0, 0, 0, 0);
        tick();
        check_output("after_abort_wren",   32'(ram_wren),   32'd0);
        check_output("after_abort_busy",   32'(busy),       32'd0);
        check_output("after_abort_rdaddr", 32'(ram_rdaddr), 32'd9);
        tick();
        check_output("after_abort_wren2", 32'(ram_wren), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
